// File: rtl/keyed_bridge_fsm_if.sv
// keyed_bridge_fsm_if -- bus bundle for keyed_bridge_fsm.
//   Request side (driven by master): start, len[3:0], data_in[DW-1:0],
//     sink_rdy, key[KEY_W-1:0].
//   Status side (driven by slave): busy, out_vld, data_out[DW-1:0], done,
//     locked.
// The bridge is connected through the slave modport. The stimulus or
// upstream logic is connected through the master modport.
interface keyed_bridge_if #(
  parameter int KEY_W = 4,
  parameter int DW    = 8
);
  logic             start;
  logic [3:0]       len;
  logic [DW-1:0]    data_in;
  logic             sink_rdy;
  logic [KEY_W-1:0] key;
  logic             busy;
  logic             out_vld;
  logic [DW-1:0]    data_out;
  logic             done;
  logic             locked;

  modport master (
    output start, len, data_in, sink_rdy, key,
    input  busy, out_vld, data_out, done, locked
  );

  modport slave (
    input  start, len, data_in, sink_rdy, key,
    output busy, out_vld, data_out, done, locked
  );
endinterface

// File: rtl/keyed_bridge_fsm.sv
// keyed_bridge_fsm -- keyed burst bridge.
// A transaction first walks one checkpoint per key bit, comparing key[ci]
// against KEY_VAL[ci] as each checkpoint is entered. It then streams
// len+1 beats from data_in to data_out under sink_rdy flow control, and
// finally pulses done for one cycle. Key mismatches are counted in a
// saturating 4-bit counter (mc) that survives across transactions.
//
// Ports:
//   clk  - clock; all state changes on the FALLING edge
//   rst  - asynchronous active-high reset
//   bus  - keyed_bridge_if.slave
//          (start/len/data_in/sink_rdy/key in; busy/out_vld/data_out/done/locked out)
//
// Optional feature: macro KEYED_BRIDGE_TRAP_EN.
//   When it is defined, the mismatch that brings mc up to TRAP_CNT diverts
//   the FSM into LOCK. Only rst leaves LOCK.
//   When it is undefined, LOCK cannot be reached and locked is tied low.
module keyed_bridge_fsm #(
  parameter int               KEY_W    = 4,
  parameter logic [KEY_W-1:0] KEY_VAL  = KEY_W'(4'b1010),
  parameter int               DW       = 8,
  parameter int               TRAP_CNT = 3
) (
  input logic           clk,
  input logic           rst,
  keyed_bridge_if.slave bus
);

  localparam int              CI_W    = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam logic [CI_W-1:0] CI_LAST = CI_W'(KEY_W - 1);

  // Reject illegal configurations at elaboration time.
  if (KEY_W < 1 || KEY_W > 8) begin : g_bad_key_w
    $error("keyed_bridge_fsm: KEY_W must be 1..8");
  end
  if (TRAP_CNT < 1 || TRAP_CNT > 15) begin : g_bad_trap_cnt
    $error("keyed_bridge_fsm: TRAP_CNT must be 1..15");
  end

`ifdef KEYED_BRIDGE_TRAP_EN
  localparam logic [3:0] TRAP_MC = 4'(TRAP_CNT);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHK   = 3'd1,
    S_CHK_D = 3'd2,
    S_XFER  = 3'd3,
    S_DONE  = 3'd4,
    S_LOCK  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CI_W-1:0] ci_q, ci_d;
  logic [3:0]      bc_q, bc_d;
  logic [3:0]      mc_q, mc_d;

  logic             enter_ckpt;
  logic [CI_W-1:0]  enter_idx;
  logic             miss;
  logic [KEY_W-1:0] key_ok;

  // Per-checkpoint key comparison. Only the bit of the checkpoint being
  // entered matters in any given cycle.
  for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key_cmp
    assign key_ok[gi] = (bus.key[gi] == KEY_VAL[gi]);
  end

  always_comb begin
    state_d    = state_q;
    ci_d       = ci_q;
    bc_d       = bc_q;
    mc_d       = mc_q;
    enter_ckpt = 1'b0;
    enter_idx  = '0;
    miss       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          enter_ckpt = 1'b1;
          enter_idx  = '0;
          bc_d       = bus.len;
        end
      end
      // The primary and duplicate checkpoint states behave identically.
      // The duplicate state only records that a mismatch happened.
      S_CHK, S_CHK_D: begin
        if (ci_q == CI_LAST) begin
          state_d = S_XFER;
        end else begin
          enter_ckpt = 1'b1;
          enter_idx  = ci_q + 1'b1;
        end
      end
      S_XFER: begin
        if (bus.sink_rdy) begin
          if (bc_q == 4'd0) begin
            state_d = S_DONE;
          end else begin
            bc_d = bc_q - 4'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef KEYED_BRIDGE_TRAP_EN
      S_LOCK: state_d = S_LOCK;
`endif
      default: state_d = S_IDLE;
    endcase

    // Checkpoint entry: choose the primary or duplicate state for index
    // enter_idx.
    if (enter_ckpt) begin
      ci_d = enter_idx;
      if (key_ok[enter_idx]) begin
        state_d = S_CHK;
      end else begin
        state_d = S_CHK_D;
        miss    = 1'b1;
      end
    end

    // The mismatch counter saturates at 15.
    // The trap fires only on the increment that lands exactly on TRAP_CNT.
    if (miss && (mc_q != 4'hF)) begin
      mc_d = mc_q + 4'd1;
`ifdef KEYED_BRIDGE_TRAP_EN
      if (mc_d == TRAP_MC) begin
        state_d = S_LOCK;
      end
`endif
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ci_q    <= '0;
      bc_q    <= '0;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      ci_q    <= ci_d;
      bc_q    <= bc_d;
      mc_q    <= mc_d;
    end
  end

  // Outputs are decoded from the registered state only.
  // data_out passes data_in straight through while in XFER.
  assign bus.busy     = (state_q == S_CHK) || (state_q == S_CHK_D) ||
                        (state_q == S_XFER) || (state_q == S_DONE);
  assign bus.out_vld  = (state_q == S_XFER);
  assign bus.data_out = (state_q == S_XFER) ? bus.data_in : '0;
  assign bus.done     = (state_q == S_DONE);
`ifdef KEYED_BRIDGE_TRAP_EN
  assign bus.locked   = (state_q == S_LOCK);
`else
  assign bus.locked   = 1'b0;
`endif

endmodule
